can_tx_scheduler: RTL and testbench

Transmit scheduler sitting between host-side TX mailboxes and `can_frame_transmitter`. It stores up to `NUM_MB` pending standard-ID frames and picks the highest-priority one (lowest ID). It launches that frame on the transmitter, interprets the outcome and decides whether to retire the frame, retry it, or re-arbitrate. It owns retransmission policy, so the transmitter only ever sees a single frame attempt.

---
 rtl/can_pkg.sv | 29 ++
 rtl/can_tx_prio_sel.sv | 39 +++
 rtl/can_tx_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// ============================================================================
// Module      : can_pkg
// Description : Shared CAN constants, frame struct and TX scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package can_pkg;

    localparam int CAN_ID_W    = 11;
    localparam int CAN_MAX_DLC = 8;

    typedef struct packed {
        logic [CAN_ID_W-1:0] id;
        logic                rtr;
        logic [3:0]          dlc;
        logic [63:0]         data;
    } can_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/can_tx_prio_sel.sv
// ============================================================================
// Module      : can_tx_prio_sel
// Description : Combinational lowest-ID selector over a request mask;
//               equal IDs resolve to the lowest mailbox index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_tx_prio_sel
    import can_pkg::*;
#(
    parameter int NUM_MB = 4,
    parameter int IDX_W  = $clog2(NUM_MB)
) (
    input  logic [NUM_MB-1:0]               req_i,
    input  logic [NUM_MB-1:0][CAN_ID_W-1:0] ids_i,
    output logic [IDX_W-1:0]                win_idx_o,
    output logic                            win_valid_o
);

    logic [CAN_ID_W-1:0] w_best_id;

    // Linear scan; strict less-than keeps the earlier index on a tie.
    always_comb begin
        win_valid_o = 1'b0;
        win_idx_o   = '0;
        w_best_id   = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (req_i[i] && (!win_valid_o || (ids_i[i] < w_best_id))) begin
                win_valid_o = 1'b1;
                win_idx_o   = IDX_W'(i);
                w_best_id   = ids_i[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/can_tx_scheduler.sv
// ============================================================================
// Module      : can_tx_scheduler
// Description : Mailbox-based CAN TX scheduler: lowest-ID arbitration,
//               single-attempt launch, retry/abort/retire policy.
//               Optional build macro CAN_TX_SCHED_ONESHOT_EN removes the
//               retry counters; any error or lost arbitration fails the frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int NUM_MB   = 4,
    parameter int MAX_RETX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_MB)-1:0]   wr_idx,
    input  logic [CAN_ID_W-1:0]         wr_id,
    input  logic                        wr_rtr,
    input  logic [3:0]                  wr_dlc,
    input  logic [63:0]                 wr_data,
    output logic                        wr_reject,
    input  logic                        abort_en,
    input  logic [$clog2(NUM_MB)-1:0]   abort_idx,
    output logic                        tx_start,
    output logic [CAN_ID_W-1:0]         tx_id,
    output logic                        tx_rtr,
    output logic                        tx_ide,
    output logic [3:0]                  tx_dlc,
    output logic [63:0]                 tx_data,
    input  logic                        tx_ok,
    input  logic                        tx_arb_lost,
    input  logic                        tx_err,
    output logic [NUM_MB-1:0]           mb_pending,
    output logic [NUM_MB-1:0]           mb_done,
    output logic [NUM_MB-1:0]           mb_fail,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_MB);

    sched_state_t          state_q, state_d;
    can_frame_t            mb_q [NUM_MB];
    logic [NUM_MB-1:0]     pending_q, done_q, fail_q;
    logic [IDX_W-1:0]      cur_q;
    logic                  wr_reject_q;
    can_frame_t            tx_q;

    logic                  w_inflight, w_abort_inflight, w_abort_idle;
    logic                  w_wr_ok, w_wr_reject;
    logic                  w_err, w_arb, w_ok;
    logic                  w_retire_done, w_retire_fail;
    logic [NUM_MB-1:0]     w_sel_mask;
    logic [NUM_MB-1:0][CAN_ID_W-1:0] w_ids;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_valid;
    can_frame_t            w_wr_frame;

    assign w_inflight       = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign w_abort_inflight = abort_en && w_inflight && (abort_idx == cur_q);
    assign w_abort_idle     = abort_en && pending_q[abort_idx] && !w_abort_inflight;
    // The in-flight mailbox stays pending, so one test covers both cases.
    assign w_wr_ok          = wr_en && !pending_q[wr_idx] && !(abort_en && (abort_idx == wr_idx));
    assign w_wr_reject      = wr_en && !w_wr_ok;

    // Outcome decode with priority err > arb_lost > ok, only in WAIT.
    assign w_err = (state_q == ST_WAIT) && tx_err;
    assign w_arb = (state_q == ST_WAIT) && !tx_err && tx_arb_lost;
    assign w_ok  = (state_q == ST_WAIT) && !tx_err && !tx_arb_lost && tx_ok;

    assign w_wr_frame.id   = wr_id;
    assign w_wr_frame.rtr  = wr_rtr;
    assign w_wr_frame.dlc  = (wr_dlc > 4'(CAN_MAX_DLC)) ? 4'(CAN_MAX_DLC) : wr_dlc;
    assign w_wr_frame.data = wr_data;

    // Selector inputs: a mailbox being aborted this cycle cannot win.
    always_comb begin
        w_sel_mask = pending_q;
        if (w_abort_idle) begin
            w_sel_mask[abort_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_MB; i++) begin
            w_ids[i] = mb_q[i].id;
        end
    end

    can_tx_prio_sel #(
        .NUM_MB (NUM_MB),
        .IDX_W  (IDX_W)
    ) u_prio_sel (
        .req_i       (w_sel_mask),
        .ids_i       (w_ids),
        .win_idx_o   (w_win_idx),
        .win_valid_o (w_win_valid)
    );

`ifdef CAN_TX_SCHED_ONESHOT_EN
    assign w_retire_done = w_ok;
    assign w_retire_fail = w_err || w_arb;
`else
    localparam int CNT_W = $clog2(MAX_RETX + 2);

    logic [CNT_W-1:0] cnt_q [NUM_MB];
    logic [CNT_W-1:0] w_cnt_next;
    logic             abort_req_q;
    logic             w_abort_eff;

    assign w_cnt_next    = cnt_q[cur_q] + CNT_W'(1);
    assign w_abort_eff   = abort_req_q || w_abort_inflight;
    assign w_retire_done = w_ok;
    assign w_retire_fail = (w_err && (w_abort_eff || (int'(w_cnt_next) > MAX_RETX)))
                        || (w_arb && w_abort_eff);

    // Per-mailbox error retry counters, cleared whenever the frame retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (w_abort_idle) begin
                cnt_q[abort_idx] <= '0;
            end
            if (w_retire_done || w_retire_fail) begin
                cnt_q[cur_q] <= '0;
            end else if (w_err) begin
                cnt_q[cur_q] <= w_cnt_next;
            end
        end
    end

    // Abort of the in-flight frame is remembered until the outcome arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_req_q <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            abort_req_q <= 1'b0;
        end else if (w_abort_inflight) begin
            abort_req_q <= 1'b1;
        end
    end
`endif

    // Next-state logic for the launch sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pending_q != '0) state_d = ST_SELECT;
            ST_SELECT: state_d = w_win_valid ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (w_err || w_arb || w_ok) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register, winner capture and registered frame fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            tx_q        <= '0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_reject_q <= w_wr_reject;
            if ((state_q == ST_SELECT) && w_win_valid) begin
                cur_q <= w_win_idx;
                tx_q  <= mb_q[w_win_idx];
            end
        end
    end

    // Mailbox storage, pending flags and retire pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MB; i++) begin
                mb_q[i] <= '0;
            end
            pending_q <= '0;
            done_q    <= '0;
            fail_q    <= '0;
        end else begin
            done_q <= '0;
            fail_q <= '0;
            if (w_wr_ok) begin
                mb_q[wr_idx]      <= w_wr_frame;
                pending_q[wr_idx] <= 1'b1;
            end
            if (w_abort_idle) begin
                pending_q[abort_idx] <= 1'b0;
                fail_q[abort_idx]    <= 1'b1;
            end
            if (w_retire_done) begin
                pending_q[cur_q] <= 1'b0;
                done_q[cur_q]    <= 1'b1;
            end
            if (w_retire_fail) begin
                pending_q[cur_q] <= 1'b0;
                fail_q[cur_q]    <= 1'b1;
            end
        end
    end

    assign tx_start   = (state_q == ST_LAUNCH);
    assign busy       = w_inflight;
    assign tx_id      = tx_q.id;
    assign tx_rtr     = tx_q.rtr;
    assign tx_ide     = 1'b0;
    assign tx_dlc     = tx_q.dlc;
    assign tx_data    = tx_q.data;
    assign wr_reject  = wr_reject_q;
    assign mb_pending = pending_q;
    assign mb_done    = done_q;
    assign mb_fail    = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
// ============================================================================
// Module      : tb_can_tx_scheduler
// Description : Directed self-checking bench for can_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_tx_scheduler;

`ifdef CAN_TX_SCHED_ONESHOT_EN
    localparam int EXP_LAUNCHES = 1;
`else
    localparam int EXP_LAUNCHES = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_rtr, abort_en;
    logic [1:0]  wr_idx, abort_idx;
    logic [10:0] wr_id;
    logic [3:0]  wr_dlc;
    logic [63:0] wr_data;
    logic        wr_reject, tx_start, tx_rtr, tx_ide, busy;
    logic [10:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        tx_ok, tx_arb_lost, tx_err;
    logic [3:0]  mb_pending, mb_done, mb_fail;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    can_tx_scheduler #(.NUM_MB(4), .MAX_RETX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_id(wr_id), .wr_rtr(wr_rtr),
        .wr_dlc(wr_dlc), .wr_data(wr_data), .wr_reject(wr_reject),
        .abort_en(abort_en), .abort_idx(abort_idx),
        .tx_start(tx_start), .tx_id(tx_id), .tx_rtr(tx_rtr), .tx_ide(tx_ide),
        .tx_dlc(tx_dlc), .tx_data(tx_data),
        .tx_ok(tx_ok), .tx_arb_lost(tx_arb_lost), .tx_err(tx_err),
        .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
        .busy(busy)
    );

    // Called at a negedge; returns at the negedge after the write was sampled.
    task automatic write_mb(input int idx, input logic [10:0] id,
                            input logic [3:0] dlc, input logic [63:0] data);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_id = id; wr_rtr = 1'b0;
        wr_dlc = dlc; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("FAIL %s_start_timeout got=%b exp=1", name, tx_start);
        end
    endtask

    // kind: 0 = ok, 1 = arbitration lost, 2 = error
    task automatic respond(input int kind);
        @(negedge clk);
        tx_ok = (kind == 0); tx_arb_lost = (kind == 1); tx_err = (kind == 2);
        @(negedge clk);
        tx_ok = 1'b0; tx_arb_lost = 1'b0; tx_err = 1'b0;
    endtask

    task automatic no_start(input int cycles, input string name);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s_no_start got=%0d exp=0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; abort_en = 1'b0; wr_idx = '0; abort_idx = '0;
        wr_id = '0; wr_rtr = 1'b0; wr_dlc = '0; wr_data = '0;
        tx_ok = 1'b0; tx_arb_lost = 1'b0; tx_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tx_start, busy, wr_reject, tx_ide, tx_rtr, mb_pending, mb_done, mb_fail,
             tx_id, tx_dlc, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b %h %h %h %h exp=all_zero",
                     tx_start, busy, wr_reject, mb_pending, mb_done, mb_fail, tx_id);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        write_mb(0, 11'h123, 4'd2, 64'hAABB_0000_0000_0000);
        checks++;
        if (mb_pending !== 4'b0001) begin
            failures++; $display("FAIL basic_pending got=%b exp=0001", mb_pending);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            failures++; $display("FAIL basic_early_start got=%b exp=0", tx_start);
        end
        @(negedge clk);
        checks++;
        if ({tx_start, busy, tx_ide, tx_rtr, tx_id, tx_dlc} !== {4'b1100, 11'h123, 4'd2}) begin
            failures++;
            $display("FAIL basic_launch got=start%b busy%b id%h dlc%0d exp=start1 busy1 id123 dlc2",
                     tx_start, busy, tx_id, tx_dlc);
        end
        checks++;
        if (tx_data !== 64'hAABB_0000_0000_0000) begin
            failures++; $display("FAIL basic_data got=%h exp=aabb000000000000", tx_data);
        end
        respond(0);
        checks++;
        if ({mb_done, mb_pending, busy} !== {4'b0001, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL basic_done got=done%b pend%b busy%b exp=done0001 pend0000 busy0",
                     mb_done, mb_pending, busy);
        end
        @(negedge clk);
        checks++;
        if (mb_done !== 4'b0000) begin
            failures++; $display("FAIL basic_done_pulse got=%b exp=0000", mb_done);
        end
    endtask

    task automatic test_priority();
        write_mb(1, 11'h200, 4'd3, 64'h1);
        write_mb(3, 11'h050, 4'd15, 64'h3);
        wait_start("prio1");
        checks++;
        if ({tx_id, tx_dlc} !== {11'h050, 4'd8}) begin
            failures++; $display("FAIL prio_first got=id%h dlc%0d exp=id050 dlc8", tx_id, tx_dlc);
        end
        respond(0);
        checks++;
        if (mb_done !== 4'b1000) begin
            failures++; $display("FAIL prio_done_first got=%b exp=1000", mb_done);
        end
        wait_start("prio2");
        checks++;
        if ({tx_id, tx_dlc} !== {11'h200, 4'd3}) begin
            failures++; $display("FAIL prio_second got=id%h dlc%0d exp=id200 dlc3", tx_id, tx_dlc);
        end
        respond(0);
        checks++;
        if ({mb_done, mb_pending} !== {4'b0010, 4'b0000}) begin
            failures++; $display("FAIL prio_done_second got=%b/%b exp=0010/0000", mb_done, mb_pending);
        end
    endtask

    task automatic test_tie();
        write_mb(2, 11'h100, 4'd1, 64'hC2);
        write_mb(0, 11'h100, 4'd1, 64'hA0);
        wait_start("tie1");
        checks++;
        if (tx_data !== 64'hA0) begin
            failures++; $display("FAIL tie_first got=%h exp=a0", tx_data);
        end
        respond(0);
        checks++;
        if (mb_done !== 4'b0001) begin
            failures++; $display("FAIL tie_done_first got=%b exp=0001", mb_done);
        end
        wait_start("tie2");
        respond(0);
        checks++;
        if (mb_done !== 4'b0100) begin
            failures++; $display("FAIL tie_done_second got=%b exp=0100", mb_done);
        end
    endtask

    task automatic test_preempt();
        write_mb(0, 11'h300, 4'd0, 64'h0);
        wait_start("pre1");
        write_mb(2, 11'h010, 4'd0, 64'h0);
        checks++;
        if ({wr_reject, mb_pending} !== {1'b0, 4'b0101}) begin
            failures++;
            $display("FAIL preempt_write got=rej%b pend%b exp=rej0 pend0101", wr_reject, mb_pending);
        end
        respond(1);
        checks++;
        if ({mb_done, mb_fail, mb_pending} !== {4'b0000, 4'b0000, 4'b0101}) begin
            failures++;
            $display("FAIL preempt_arb got=done%b fail%b pend%b exp=done0000 fail0000 pend0101",
                     mb_done, mb_fail, mb_pending);
        end
        wait_start("pre2");
        checks++;
        if (tx_id !== 11'h010) begin
            failures++; $display("FAIL preempt_winner got=%h exp=010", tx_id);
        end
        respond(0);
        wait_start("pre3");
        checks++;
        if (tx_id !== 11'h300) begin
            failures++; $display("FAIL preempt_relaunch got=%h exp=300", tx_id);
        end
        respond(0);
        checks++;
        if ({mb_done, mb_pending} !== {4'b0001, 4'b0000}) begin
            failures++; $display("FAIL preempt_done got=%b/%b exp=0001/0000", mb_done, mb_pending);
        end
    endtask

    task automatic test_retx();
        int         launches = 0;
        int         fail_at  = 0;
        logic [3:0] fail_val = '0;
        write_mb(1, 11'h055, 4'd1, 64'h55);
        for (int k = 1; k <= 8; k++) begin
            wait_start("retx");
            launches++;
            respond(2);
            if (mb_fail !== 4'b0000) begin
                fail_at  = k;
                fail_val = mb_fail;
                break;
            end
        end
        checks++;
        if (launches != EXP_LAUNCHES || fail_at != EXP_LAUNCHES) begin
            failures++;
            $display("FAIL retx_launches got=launches%0d fail_at%0d exp=%0d", launches, fail_at, EXP_LAUNCHES);
        end
        checks++;
        if ({fail_val, mb_pending} !== {4'b0010, 4'b0000}) begin
            failures++; $display("FAIL retx_fail got=%b/%b exp=0010/0000", fail_val, mb_pending);
        end
        no_start(10, "retx_after_fail");
    endtask

    task automatic test_abort_inflight();
        write_mb(2, 11'h077, 4'd0, 64'h0);
        wait_start("abort_inflight");
        abort_en = 1'b1; abort_idx = 2'd2;
        @(negedge clk);
        abort_en = 1'b0;
        checks++;
        if ({mb_fail, mb_pending} !== {4'b0000, 4'b0100}) begin
            failures++; $display("FAIL abort_latched got=%b/%b exp=0000/0100", mb_fail, mb_pending);
        end
        respond(2);
        checks++;
        if ({mb_fail, mb_pending} !== {4'b0100, 4'b0000}) begin
            failures++; $display("FAIL abort_retire got=%b/%b exp=0100/0000", mb_fail, mb_pending);
        end
        no_start(10, "abort_no_relaunch");
    endtask

    task automatic test_reject_abort();
        write_mb(0, 11'h400, 4'd0, 64'h0);
        write_mb(1, 11'h401, 4'd0, 64'h0);
        wait_start("rej");
        write_mb(1, 11'h7FF, 4'd0, 64'h0);
        checks++;
        if ({wr_reject, mb_pending} !== {1'b1, 4'b0011}) begin
            failures++; $display("FAIL reject_pulse got=rej%b pend%b exp=rej1 pend0011", wr_reject, mb_pending);
        end
        @(negedge clk);
        checks++;
        if (wr_reject !== 1'b0) begin
            failures++; $display("FAIL reject_one_cycle got=%b exp=0", wr_reject);
        end
        abort_en = 1'b1; abort_idx = 2'd1;
        @(negedge clk);
        abort_en = 1'b0;
        checks++;
        if ({mb_fail, mb_pending} !== {4'b0010, 4'b0001}) begin
            failures++; $display("FAIL abort_pending got=%b/%b exp=0010/0001", mb_fail, mb_pending);
        end
        wr_en = 1'b1; wr_idx = 2'd3; wr_id = 11'h003; abort_en = 1'b1; abort_idx = 2'd3;
        @(negedge clk);
        wr_en = 1'b0; abort_en = 1'b0;
        checks++;
        if ({wr_reject, mb_fail, mb_pending} !== {1'b1, 4'b0000, 4'b0001}) begin
            failures++;
            $display("FAIL write_abort_same got=rej%b fail%b pend%b exp=rej1 fail0000 pend0001",
                     wr_reject, mb_fail, mb_pending);
        end
        respond(0);
        checks++;
        if ({mb_done, mb_pending} !== {4'b0001, 4'b0000}) begin
            failures++; $display("FAIL reject_inflight_done got=%b/%b exp=0001/0000", mb_done, mb_pending);
        end
    endtask

    task automatic test_reset_midframe();
        write_mb(3, 11'h111, 4'd4, 64'hFFFF);
        wait_start("rst1");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_start, busy, mb_pending, mb_done, mb_fail, wr_reject, tx_id, tx_dlc, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_midframe got=start%b busy%b pend%b id%h exp=all_zero",
                     tx_start, busy, mb_pending, tx_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        no_start(10, "reset_quiet");
        write_mb(0, 11'h222, 4'd0, 64'h0);
        wait_start("rst2");
        checks++;
        if (tx_id !== 11'h222) begin
            failures++; $display("FAIL reset_new_frame got=%h exp=222", tx_id);
        end
        respond(0);
        checks++;
        if (mb_done !== 4'b0001) begin
            failures++; $display("FAIL reset_new_done got=%b exp=0001", mb_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_tie();
        test_preempt();
        test_retx();
        test_abort_inflight();
        test_reject_abort();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
